booth_result_collector: RTL
===========================

Name: booth_result_collector

Overview:
- Downstream stage of the sequential Booth multiplier controller/datapath.
- Captures the two result beats the multiplier emits over its shared W-bit output bus (done high for two consecutive cycles, selout=0 then selout=1) and assembles them into one 2W-bit two's-complement product.
- Buffers products in a small FWFT FIFO with a valid/ready output handshake.
- Reports protocol errors and overflow, and tells the upstream sequencer when it may issue another start.

Parameters:
- W, 5, multiplier operand width; input bus width; product is 2W bits.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- done_in  in  1  multiplier done strobe.
- selout_in  in  1  beat select from multiplier: 0 = low half beat, 1 = high half beat.
- data_in  in  W  multiplier output bus, valid while done_in=1.
- out_ready  in  1  consumer ready.
- clr_err  in  1  clears sticky error flags.
- prod  out  2W  FIFO head product, {hi, lo}.
- prod_valid  out  1  FIFO non-empty.
- mult_ok  out  1  high when the FIFO has at least one free slot not reserved by a product in assembly; upstream pulses start only while high.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- proto_err  out  1  sticky protocol error.
- ovf_err  out  1  sticky overflow: product dropped.

Behaviour:
- Reset (rst=1 at posedge):
  - FSM goes to IDLE; FIFO pointers and count go to 0.
  - prod_valid=0, prod=0, proto_err=0, ovf_err=0, mult_ok=1, lo register=0.
  - Reset mid-assembly discards the partial product.
- FSM states are IDLE and GOT_LO.
- In IDLE:
  - done_in & ~selout_in: latch lo<=data_in, go to GOT_LO.
  - done_in & selout_in: set proto_err, stay in IDLE, data ignored.
  - ~done_in: stay.
- In GOT_LO:
  - done_in & selout_in: push {data_in, lo}, go to IDLE.
  - done_in & ~selout_in: set proto_err, relatch lo<=data_in, stay in GOT_LO.
  - ~done_in: beats must be consecutive; set proto_err, discard lo, go to IDLE.
- Push:
  - Accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the product is dropped and ovf_err is set; FIFO contents are unchanged.
- Pop: occurs when prod_valid & out_ready. Pop on an empty FIFO is a no-op.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Pointers wrap modulo DEPTH.
- count updates as +1 on push only, -1 on pop only, and is unchanged otherwise.
- Latency: product appears on prod with prod_valid=1 in the cycle after the hi-beat posedge. Registered FIFO state, first-word fall-through.
- prod is stable while prod_valid=1 and out_ready=0.
- mult_ok = (count + (state==GOT_LO)) < DEPTH, combinational from registers.
- Sticky flags:
  - proto_err and ovf_err stay set until clr_err or rst.
  - If clr_err and a new error occur in the same cycle, the flag ends up set (set wins).
- No arithmetic is performed on data; the {hi, lo} concatenation is bit-exact. Sign is carried in bit 2W-1.

Test Plan:
- Basic: W=5. Beats lo=5'b01011 (sel=0), then hi=5'b11111 (sel=1), out_ready=1. Required: next cycle prod=10'h3EB (-21), prod_valid=1; count returns to 0 after the pop.
- Back-pressure/full: out_ready=0, 4 products 0x001, 0x002, 0x3FF, 0x200. Required: count=4, mult_ok=0. A 5th product (0x155) is dropped, ovf_err=1, and the head stays 0x001. Raising out_ready then drains 0x001, 0x002, 0x3FF, 0x200 in order.
- Full with simultaneous push/pop: FIFO full, out_ready=1 in the same cycle as the hi beat of 0x0AA. Required: 0x0AA is accepted, count stays 4, no ovf_err, and it is drained last.
- Protocol errors:
  - A hi beat while in IDLE sets proto_err and pushes nothing.
  - lo=0x03, then done_in=0 for 1 cycle, then hi: sets proto_err and pushes nothing.
  - lo, lo, hi sequence: proto_err=1 and the product uses the second lo.
  - clr_err clears the flag.
- Reset mid-operation: rst asserted in GOT_LO with 2 entries queued. Required: next cycle count=0, prod_valid=0, flags=0, mult_ok=1; a subsequent hi beat alone raises proto_err.
- Wrap-around: 9 consecutive products with values 0..8 under out_ready=1 with random stalls. Required: output order 0..8, with no loss and no duplication.

Source files
------------

// File: rtl/booth_result_collector_if.sv
// booth_result_collector_if: beat input bus, product output handshake and status flags
interface booth_result_collector_if #(
   parameter int W     = 5,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic          done_in;
   logic          selout_in;
   logic [W-1:0]  data_in;
   logic          out_ready;
   logic          clr_err;
   logic [2*W-1:0] prod;
   logic          prod_valid;
   logic          mult_ok;
   logic [CW-1:0] count;
   logic          proto_err;
   logic          ovf_err;
   modport master (
      output done_in, selout_in, data_in, out_ready, clr_err,
      input  prod, prod_valid, mult_ok, count, proto_err, ovf_err
   );
   modport slave (
      input  done_in, selout_in, data_in, out_ready, clr_err,
      output prod, prod_valid, mult_ok, count, proto_err, ovf_err
   );
endinterface

// File: rtl/booth_result_collector.sv
// booth_result_collector: joins lo/hi Booth result beats into 2W-bit products and queues them in a FWFT FIFO
module booth_result_collector #(
   parameter int W     = 5,
   parameter int DEPTH = 4
) (
   input logic                    clk,
   input logic                    rst,
   booth_result_collector_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic {IDLE, GOT_LO} state_t;
   state_t         state_q, state_d;
   logic [W-1:0]   lo_q, lo_d;
   logic [2*W-1:0] mem_q [DEPTH];
   logic [2*W-1:0] mem_d [DEPTH];
   logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]  count_q, count_d;
   logic           proto_q, proto_d, ovf_q, ovf_d;
   logic           push, pop, accept, proto_set;
   // beat sequencing: lo must be immediately followed by hi, anything else is a protocol error
   always_comb begin
      state_d   = state_q;
      lo_d      = lo_q;
      push      = 1'b0;
      proto_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.done_in && bus.selout_in) proto_set = 1'b1;
            else if (bus.done_in) begin
               lo_d    = bus.data_in;
               state_d = GOT_LO;
            end
         end
         GOT_LO: begin
            if (bus.done_in && bus.selout_in) begin
               push    = 1'b1;
               state_d = IDLE;
            end else if (bus.done_in) begin
               proto_set = 1'b1;
               lo_d      = bus.data_in;
            end else begin
               proto_set = 1'b1;
               lo_d      = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // FIFO bookkeeping; a pop in the same cycle frees the slot a full-FIFO push needs
   always_comb begin
      pop     = (count_q != '0) && bus.out_ready;
      accept  = push && ((count_q < CW'(DEPTH)) || pop);
      mem_d   = mem_q;
      if (accept) mem_d[wr_q] = {bus.data_in, lo_q};
      wr_d    = accept ? wr_q + 1'b1 : wr_q;
      rd_d    = pop ? rd_q + 1'b1 : rd_q;
      count_d = count_q + CW'(accept) - CW'(pop);
      proto_d = (proto_q && !bus.clr_err) || proto_set;
      ovf_d   = (ovf_q && !bus.clr_err) || (push && !accept);
   end
   // control state with synchronous reset; a reset mid-assembly drops the partial product
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lo_q    <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         proto_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         proto_q <= proto_d;
         ovf_q   <= ovf_d;
      end
   end
   // storage needs no reset: it is only visible while count is non-zero
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
   assign bus.prod_valid = (count_q != '0);
   assign bus.prod       = bus.prod_valid ? mem_q[rd_q] : '0;
   assign bus.mult_ok    = (count_q + CW'(state_q == GOT_LO)) < CW'(DEPTH);
   assign bus.count      = count_q;
   assign bus.proto_err  = proto_q;
   assign bus.ovf_err    = ovf_q;
endmodule
